// File: rtl/nvme_pcie_pkg.sv
// Shared PCIe CQ/RQ field map, request-type codes and doorbell layout for the NVMe endpoint.
// Descriptor and tuser bit positions follow the 128-bit completer-request interface.
package nvme_pcie_pkg;

    localparam logic [3:0] MEM_RD = 4'b0000;
    localparam logic [3:0] MEM_WR = 4'b0001;

    localparam int CQ_DW_CNT_LSB   = 64;
    localparam int CQ_DW_CNT_W     = 11;
    localparam int CQ_REQ_TYPE_LSB = 75;
    localparam int CQ_BAR_ID_LSB   = 112;

    localparam int TUSER_FIRST_BE_LSB = 0;
    localparam int TUSER_LAST_BE_LSB  = 4;
    localparam int TUSER_SOP_BIT      = 40;
    localparam int TUSER_DISC_BIT     = 41;

    localparam logic [15:0] DB_BASE_DEFAULT = 16'h1000;
    localparam int          DB_STRIDE       = 4;
    localparam int          DB_STRIDE_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_DESC = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } cq_state_t;

    function automatic logic [15:0] be_merge(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic [1:0]  be);
        return {be[1] ? new_val[15:8] : old_val[15:8],
                be[0] ? new_val[7:0]  : old_val[7:0]};
    endfunction

endpackage

// File: rtl/doorbell_regs.sv
// SQ tail / CQ head doorbell registers with byte-enable merge.
// The merged value is also exported so the caller can report it in the doorbell event.
module doorbell_regs
    import nvme_pcie_pkg::*;
#(
    parameter int NUM_QUEUES = 8
) (
    input  logic                    user_clk,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic                    wr_is_cq,
    input  logic [5:0]              wr_qid,
    input  logic [1:0]              wr_be,
    input  logic [15:0]             wr_data,
    output logic [15:0]             wr_merged,
    output logic [16*NUM_QUEUES-1:0] sq_tail,
    output logic [16*NUM_QUEUES-1:0] cq_head
);

    logic [15:0] old_val;

    always_comb begin
        old_val = 16'h0000;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (wr_qid == 6'(i)) begin
                old_val = wr_is_cq ? cq_head[16*i +: 16] : sq_tail[16*i +: 16];
            end
        end
    end

    assign wr_merged = be_merge(old_val, wr_data, wr_be);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
            logic [15:0] sq_reg;
            logic [15:0] cq_reg;

            always_ff @(posedge user_clk) begin
                if (clear) begin
                    sq_reg <= 16'h0000;
                    cq_reg <= 16'h0000;
                end else if (wr_en && (wr_qid == 6'(gi))) begin
                    if (wr_is_cq) begin
                        cq_reg <= wr_merged;
                    end else begin
                        sq_reg <= wr_merged;
                    end
                end
            end

            assign sq_tail[16*gi +: 16] = sq_reg;
            assign cq_head[16*gi +: 16] = cq_reg;
        end
    endgenerate

endmodule

// File: rtl/doorbell_rx.sv
// NVMe doorbell receiver: parses CQ memory writes into BAR0 doorbell space, updates
// SQ tail / CQ head registers and emits one handshaked event per successful write.
module doorbell_rx
    import nvme_pcie_pkg::*;
#(
    parameter int          C_DATA_WIDTH        = 128,
    parameter int          AXI4_CQ_TUSER_WIDTH = 88,
    parameter int          NUM_QUEUES          = 8,
    parameter logic [15:0] DB_BASE             = DB_BASE_DEFAULT
) (
    input  logic                           user_clk,
    input  logic                           user_reset_n,
    input  logic                           user_lnk_up,
    input  logic [C_DATA_WIDTH-1:0]        m_axis_cq_tdata,
    input  logic [AXI4_CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser,
    input  logic [3:0]                     m_axis_cq_tkeep,
    input  logic                           m_axis_cq_tlast,
    input  logic                           m_axis_cq_tvalid,
    output logic                           m_axis_cq_tready,
    output logic                           db_valid,
    input  logic                           db_ready,
    output logic                           db_is_cq,
    output logic [5:0]                     db_qid,
    output logic [15:0]                    db_value,
    output logic [16*NUM_QUEUES-1:0]       sq_tail,
    output logic [16*NUM_QUEUES-1:0]       cq_head,
    output logic [15:0]                    drop_cnt
);

    cq_state_t   state_reg, state_next;
    logic        ready_en_reg;
    logic        pend_is_cq_reg;
    logic [5:0]  pend_qid_reg;
    logic        db_valid_reg, db_is_cq_reg;
    logic [5:0]  db_qid_reg;
    logic [15:0] db_value_reg, drop_cnt_reg;

    logic        rst_active, beat_acc, sop, disc;
    logic [3:0]  first_be, desc_type;
    logic [2:0]  bar_id;
    logic [CQ_DW_CNT_W-1:0] dw_cnt;
    logic [15:0] offset;
    logic [16:0] offset_rel, idx_full;
    logic        in_range, desc_ok;
    logic        desc_load, wr_en;
    logic [1:0]  drop_add;
    logic [15:0] wr_merged;
    logic [16:0] drop_sum;

    assign rst_active = !user_reset_n || !user_lnk_up;
    assign beat_acc   = m_axis_cq_tvalid && m_axis_cq_tready;
    assign sop        = m_axis_cq_tuser[TUSER_SOP_BIT];
    assign disc       = m_axis_cq_tuser[TUSER_DISC_BIT];
    assign first_be   = m_axis_cq_tuser[TUSER_FIRST_BE_LSB +: 4];
    assign desc_type  = m_axis_cq_tdata[CQ_REQ_TYPE_LSB +: 4];
    assign dw_cnt     = m_axis_cq_tdata[CQ_DW_CNT_LSB +: CQ_DW_CNT_W];
    assign bar_id     = m_axis_cq_tdata[CQ_BAR_ID_LSB +: 3];
    assign offset     = {m_axis_cq_tdata[15:2], 2'b00};

    // 17-bit arithmetic so a doorbell window near the top of the BAR cannot wrap
    assign offset_rel = {1'b0, offset} - {1'b0, DB_BASE};
    assign idx_full   = offset_rel >> DB_STRIDE_SHIFT;
    assign in_range   = (offset >= DB_BASE) &&
                        ({1'b0, offset} < ({1'b0, DB_BASE} + 17'(2 * DB_STRIDE * NUM_QUEUES)));
    assign desc_ok    = (desc_type == MEM_WR) && (bar_id == 3'd0) &&
                        ((dw_cnt == 11'd1) || (dw_cnt == 11'd2)) &&
                        in_range && (offset[1:0] == 2'b00) && !m_axis_cq_tlast;

    always_ff @(posedge user_clk) begin
        if (rst_active) begin
            state_reg    <= ST_DESC;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ready_en_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_DESC: begin
                if (beat_acc && sop) begin
                    state_next = desc_ok ? ST_DATA : (m_axis_cq_tlast ? ST_DESC : ST_DROP);
                end
            end
            ST_DATA: begin
                if (beat_acc) begin
                    if (sop) begin
                        state_next = desc_ok ? ST_DATA : (m_axis_cq_tlast ? ST_DESC : ST_DROP);
                    end else begin
                        state_next = m_axis_cq_tlast ? ST_DESC : ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (beat_acc && m_axis_cq_tlast) begin
                    state_next = ST_DESC;
                end
            end
            default: state_next = ST_DESC;
        endcase
    end

    always_comb begin
        m_axis_cq_tready = ready_en_reg && !(db_valid_reg && !db_ready && (state_reg == ST_DATA));
        desc_load        = 1'b0;
        wr_en            = 1'b0;
        drop_add         = 2'd0;
        case (state_reg)
            ST_DESC: begin
                if (beat_acc && sop) begin
                    desc_load = desc_ok;
                    drop_add  = desc_ok ? 2'd0 : 2'd1;
                end
            end
            ST_DATA: begin
                if (beat_acc) begin
                    if (sop) begin
                        // pending write is abandoned; the new descriptor may itself be bad
                        desc_load = desc_ok;
                        drop_add  = desc_ok ? 2'd1 : 2'd2;
                    end else if (m_axis_cq_tlast && !disc) begin
                        wr_en = 1'b1;
                    end else begin
                        drop_add = 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign drop_sum = {1'b0, drop_cnt_reg} + 17'(drop_add);

    always_ff @(posedge user_clk) begin
        if (rst_active) begin
            pend_is_cq_reg <= 1'b0;
            pend_qid_reg   <= 6'd0;
            db_valid_reg   <= 1'b0;
            db_is_cq_reg   <= 1'b0;
            db_qid_reg     <= 6'd0;
            db_value_reg   <= 16'h0000;
            drop_cnt_reg   <= 16'h0000;
        end else begin
            if (desc_load) begin
                pend_is_cq_reg <= idx_full[0];
                pend_qid_reg   <= idx_full[6:1];
            end
            if (wr_en) begin
                db_valid_reg <= 1'b1;
                db_is_cq_reg <= pend_is_cq_reg;
                db_qid_reg   <= pend_qid_reg;
                db_value_reg <= wr_merged;
            end else if (db_ready) begin
                db_valid_reg <= 1'b0;
            end
            drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    doorbell_regs #(
        .NUM_QUEUES (NUM_QUEUES)
    ) u_regs (
        .user_clk  (user_clk),
        .clear     (rst_active),
        .wr_en     (wr_en),
        .wr_is_cq  (pend_is_cq_reg),
        .wr_qid    (pend_qid_reg),
        .wr_be     (first_be[1:0]),
        .wr_data   (m_axis_cq_tdata[15:0]),
        .wr_merged (wr_merged),
        .sq_tail   (sq_tail),
        .cq_head   (cq_head)
    );

    assign db_valid = db_valid_reg;
    assign db_is_cq = db_is_cq_reg;
    assign db_qid   = db_qid_reg;
    assign db_value = db_value_reg;
    assign drop_cnt = drop_cnt_reg;

    logic unused_ok;
    assign unused_ok = ^{m_axis_cq_tkeep, m_axis_cq_tdata, m_axis_cq_tuser,
                         m_axis_cq_tuser[TUSER_LAST_BE_LSB +: 4], first_be[3:2],
                         offset_rel, idx_full, desc_type == MEM_RD};

endmodule
